// File: rtl/hier_path_pkg.sv
// Shared types and elaboration helpers for the hierarchical path decoder.
package hier_path_pkg;

  localparam int DEF_LEVELS = 10;
  localparam int DEF_RADIX  = 5;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Number of distinct paths of the given length; used to size the index bus.
  function automatic longint unsigned radix_pow(input int levels, input int radix = DEF_RADIX);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < levels; i++) p = p * longint'(radix);
    return p;
  endfunction

endpackage

// File: rtl/hier_path_mac.sv
// One Horner step: next = acc*RADIX + digit, plus digit legality.
module hier_path_mac #(
  parameter int RADIX   = 5,
  parameter int DIGIT_W = 3,
  parameter int IDX_W   = 24
) (
  input  logic [IDX_W-1:0]   acc_i,
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [IDX_W-1:0]   next_acc_o,
  output logic               digit_ok_o
);

  localparam int WW = IDX_W + DIGIT_W;

  logic [WW-1:0] wide;

  // Widened so the product cannot wrap before the final truncation.
  assign wide       = {{DIGIT_W{1'b0}}, acc_i} * WW'(RADIX) + {{IDX_W{1'b0}}, digit_i};
  assign next_acc_o = IDX_W'(wide);
  assign digit_ok_o = digit_i < DIGIT_W'(RADIX);

endmodule

// File: rtl/hier_path_decoder.sv
// Collects per-level child-select digits into a flat node index and depth,
// flagging out-of-range digits and over-long paths.
module hier_path_decoder
  import hier_path_pkg::*;
#(
  parameter int LEVELS  = DEF_LEVELS,
  parameter int RADIX   = DEF_RADIX,
  parameter int DIGIT_W = 3,
  parameter int IDX_W   = 24,
  parameter int DEPTH_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               digit_valid,
  output logic               digit_ready,
  input  logic [DIGIT_W-1:0] digit,
  input  logic               digit_last,
  output logic               idx_valid,
  input  logic               idx_ready,
  output logic [IDX_W-1:0]   idx,
  output logic [DEPTH_W-1:0] depth,
  output logic               err_range,
  output logic               err_depth
);

  if (IDX_W < $clog2(radix_pow(LEVELS, RADIX))) begin : g_idx_w_chk
    $error("IDX_W too narrow for RADIX**LEVELS");
  end
  if ((1 << DEPTH_W) <= LEVELS + 1) begin : g_depth_w_chk
    $error("DEPTH_W too narrow for LEVELS+1");
  end
  if ((1 << DIGIT_W) <= RADIX) begin : g_digit_w_chk
    $error("DIGIT_W too narrow for RADIX");
  end

  localparam logic [DEPTH_W-1:0] CNT_MAX = DEPTH_W'(LEVELS + 1);
  localparam logic [DEPTH_W-1:0] CNT_LIM = DEPTH_W'(LEVELS);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   acc_q, acc_d;
  logic [DEPTH_W-1:0] cnt_q, cnt_d;
  logic               erng_q, erng_d;
  logic               edep_q, edep_d;

  logic [IDX_W-1:0]   next_acc;
  logic               digit_ok;
  logic               dig_take;
  logic               res_take;
  logic [DEPTH_W-1:0] cnt_inc;

  hier_path_mac #(
    .RADIX  (RADIX),
    .DIGIT_W(DIGIT_W),
    .IDX_W  (IDX_W)
  ) u_mac (
    .acc_i     (acc_q),
    .digit_i   (digit),
    .next_acc_o(next_acc),
    .digit_ok_o(digit_ok)
  );

  assign digit_ready = (state_q != HOLD);
  assign idx_valid   = (state_q == HOLD);
  assign dig_take    = digit_valid && digit_ready;
  assign res_take    = idx_valid && idx_ready;
  assign cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  // Result fields come straight from the path registers; an errored path reports index 0.
  assign idx       = (erng_q || edep_q) ? '0 : acc_q;
  assign depth     = cnt_q;
  assign err_range = erng_q;
  assign err_depth = edep_q;

  // Path state register; reset abandons any partial path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      erng_q  <= 1'b0;
      edep_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      erng_q  <= erng_d;
      edep_q  <= edep_d;
    end
  end

  // Next-state: accumulate, drain an errored path to its last digit, hold the result.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    erng_d  = erng_q;
    edep_d  = edep_q;
    case (state_q)
      ACCUM: begin
        if (dig_take) begin
          cnt_d = cnt_inc;
          if (!digit_ok)              erng_d = 1'b1;
          else if (cnt_q == CNT_LIM)  edep_d = 1'b1;
          else                        acc_d  = next_acc;
          if (digit_last)                          state_d = HOLD;
          else if (!digit_ok || cnt_q == CNT_LIM)  state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (dig_take) begin
          cnt_d = cnt_inc;
          if (!digit_ok)             erng_d = 1'b1;
          else if (cnt_q >= CNT_LIM) edep_d = 1'b1;
          if (digit_last) state_d = HOLD;
        end
      end
      HOLD: begin
        if (res_take) begin
          state_d = ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
          erng_d  = 1'b0;
          edep_d  = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

endmodule

// File: tb/tb_hier_path_decoder.sv
module tb_hier_path_decoder;

  localparam int LEVELS  = 10;
  localparam int RADIX   = 5;
  localparam int DIGIT_W = 3;
  localparam int IDX_W   = 24;
  localparam int DEPTH_W = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               digit_valid;
  logic               digit_ready;
  logic [DIGIT_W-1:0] digit;
  logic               digit_last;
  logic               idx_valid;
  logic               idx_ready;
  logic [IDX_W-1:0]   idx;
  logic [DEPTH_W-1:0] depth;
  logic               err_range;
  logic               err_depth;

  int checks = 0;
  int errors = 0;

  hier_path_decoder #(
    .LEVELS(LEVELS), .RADIX(RADIX), .DIGIT_W(DIGIT_W), .IDX_W(IDX_W), .DEPTH_W(DEPTH_W)
  ) dut (
    .clk(clk), .rst(rst),
    .digit_valid(digit_valid), .digit_ready(digit_ready),
    .digit(digit), .digit_last(digit_last),
    .idx_valid(idx_valid), .idx_ready(idx_ready),
    .idx(idx), .depth(depth),
    .err_range(err_range), .err_depth(err_depth)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Reference: what the path names, computed from the whole digit list at once.
  task automatic model(input int unsigned ds[$], output longint e_idx, output int e_depth,
                       output int e_rng, output int e_dep);
    longint a;
    a = 0; e_rng = 0; e_dep = 0;
    for (int i = 0; i < ds.size(); i++) begin
      if (ds[i] >= RADIX) e_rng = 1;
      else if (i >= LEVELS) e_dep = 1;
      else a = a * RADIX + ds[i];
    end
    e_depth = (ds.size() > LEVELS + 1) ? LEVELS + 1 : ds.size();
    e_idx   = (e_rng || e_dep) ? 0 : a;
  endtask

  // Present one digit and wait (bounded) until it is accepted.
  task automatic put_digit(input int unsigned d, input bit last);
    int guard;
    guard = 0;
    digit_valid = 1'b1;
    digit       = DIGIT_W'(d);
    digit_last  = last;
    while (!digit_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) chk("ready_timeout", 0, 1);
    @(posedge clk); #1;
    digit_valid = 1'b0;
    digit_last  = 1'b0;
  endtask

  task automatic take();
    idx_ready = 1'b1;
    @(posedge clk); #1;
    idx_ready = 1'b0;
    chk("take_vld", idx_valid, 0);
    chk("take_rdy", digit_ready, 1);
  endtask

  // Drive a whole path with random idle gaps, then check and consume the result.
  task automatic send_path(input int unsigned ds[$], input bit gaps, input int hold);
    longint e_idx;
    int     e_depth, e_rng, e_dep;
    logic [IDX_W-1:0]   idx0;
    logic [DEPTH_W-1:0] dep0;
    model(ds, e_idx, e_depth, e_rng, e_dep);
    for (int i = 0; i < ds.size(); i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          digit_last = 1'($urandom_range(0, 1));
          digit      = DIGIT_W'($urandom);
          @(posedge clk); #1;
        end
        digit_last = 1'b0;
      end
      put_digit(ds[i], i == ds.size() - 1);
    end
    chk("res_vld", idx_valid, 1);
    chk("res_idx", idx, e_idx);
    chk("res_depth", depth, e_depth);
    chk("res_erng", err_range, e_rng);
    chk("res_edep", err_depth, e_dep);
    idx0 = idx;
    dep0 = depth;
    repeat (hold) begin
      digit_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk("hold_vld", idx_valid, 1);
      chk("hold_rdy", digit_ready, 0);
      chk("hold_idx", idx, idx0);
      chk("hold_depth", depth, dep0);
    end
    digit_valid = 1'b0;
    take();
  endtask

  initial begin
    int unsigned ds[$];
    logic [IDX_W-1:0] idx0;
    rst = 1'b1; digit_valid = 1'b0; digit = '0; digit_last = 1'b0; idx_ready = 1'b0;
    #12;
    chk("rst_vld", idx_valid, 0);
    chk("rst_idx", idx, 0);
    chk("rst_depth", depth, 0);
    chk("rst_erng", err_range, 0);
    chk("rst_edep", err_depth, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_rdy", digit_ready, 1);

    // Basic path, fixed-value check of the decoded index.
    ds = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 0};
    foreach (ds[i]) put_digit(ds[i], i == 9);
    chk("p155_vld", idx_valid, 1);
    chk("p155_idx", idx, 155);
    chk("p155_depth", depth, 10);
    chk("p155_err", {err_range, err_depth}, 0);
    take();

    ds = '{4};
    send_path(ds, 0, 0);
    ds = '{4, 4, 4, 4, 4, 4, 4, 4, 4, 4};
    send_path(ds, 0, 0);
    chk("max_idx_ref", radix_max(), 9765624);
    ds = '{2, 5, 1};
    send_path(ds, 0, 1);
    ds = '{3};
    send_path(ds, 0, 0);
    ds = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    send_path(ds, 0, 2);

    // Backpressure in HOLD with the next digit already waiting.
    put_digit(1, 1);
    digit_valid = 1'b1; digit = 3'd3; digit_last = 1'b1;
    idx0 = idx;
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp_rdy", digit_ready, 0);
      chk("bp_vld", idx_valid, 1);
      chk("bp_idx", idx, idx0);
      chk("bp_depth", depth, 1);
    end
    idx_ready = 1'b1;
    @(posedge clk); #1;
    idx_ready = 1'b0;
    chk("bp_take_vld", idx_valid, 0);
    chk("bp_take_rdy", digit_ready, 1);
    @(posedge clk); #1;
    digit_valid = 1'b0; digit_last = 1'b0;
    chk("bp_next_vld", idx_valid, 1);
    chk("bp_next_idx", idx, 3);
    take();

    // Reset mid-path discards the partial path.
    put_digit(2, 0); put_digit(3, 0); put_digit(4, 0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_depth", depth, 0);
    chk("mid_rst_vld", idx_valid, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_noout", idx_valid, 0);
    ds = '{1, 2};
    send_path(ds, 0, 0);

    // Reset while holding a result drops idx_valid without a clock edge.
    put_digit(4, 1);
    chk("hrst_pre", idx_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("hrst_vld", idx_valid, 0);
    chk("hrst_idx", idx, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Random paths, including illegal digits and over-long paths.
    for (int p = 0; p < 60; p++) begin
      int n;
      ds = {};
      n = $urandom_range(1, 13);
      for (int i = 0; i < n; i++)
        ds.push_back(($urandom_range(0, 9) == 0) ? $urandom_range(RADIX, 7) : $urandom_range(0, RADIX - 1));
      send_path(ds, 1, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  function automatic longint radix_max();
    longint p;
    p = 1;
    for (int i = 0; i < LEVELS; i++) p = p * RADIX;
    return p - 1;
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
